// File: rtl/pc_unit.sv
// pc_unit: program counter for the 6502-compatible core.
// Supports hold, increment, two-byte absolute jump, byte-wise stack loads,
// and signed relative branches. A branch that carries or borrows out of the
// low byte takes one extra fix-up cycle to adjust the high byte.
//
// Ports:
//   clk_1       in   1  system clock, all state updates on posedge
//   rst         in   1  asynchronous active-high reset
//   pc_op       in   3  operation select, sampled while not busy
//   data_bus    in   8  jump byte, stack byte, or branch offset
//   pc_out      out 16  registered program counter (feeds the address buffer)
//   busy        out  1  high during the branch fix-up cycle
//   page_cross  out  1  high for exactly the fix-up cycle of a page-crossing branch
module pc_unit #(
   parameter logic [15:0] RESET_PC = 16'hFFFC
) (
   input  logic        clk_1,
   input  logic        rst,
   input  logic [2:0]  pc_op,
   input  logic [7:0]  data_bus,
   output logic [15:0] pc_out,
   output logic        busy,
   output logic        page_cross
);

   localparam int unsigned PC_W   = 16;
   localparam int unsigned BYTE_W = 8;

   localparam logic [2:0] OP_HOLD     = 3'd0;
   localparam logic [2:0] OP_INC      = 3'd1;
   localparam logic [2:0] OP_LATCH_LO = 3'd2;
   localparam logic [2:0] OP_JUMP     = 3'd3;
   localparam logic [2:0] OP_BRANCH   = 3'd4;
   localparam logic [2:0] OP_SET_LO   = 3'd5;
   localparam logic [2:0] OP_SET_HI   = 3'd6;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_FIXUP = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [BYTE_W-1:0]   temp_lo_q, temp_lo_d;
   logic                dir_q, dir_d;        // 1: high byte decrements in fix-up
   logic                busy_q, busy_d;
   logic                page_cross_q, page_cross_d;
   logic [BYTE_W:0]     sum;

   // State and datapath registers
   always_ff @(posedge clk_1 or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         temp_lo_q    <= '0;
         dir_q        <= 1'b0;
         busy_q       <= 1'b0;
         page_cross_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         temp_lo_q    <= temp_lo_d;
         dir_q        <= dir_d;
         busy_q       <= busy_d;
         page_cross_q <= page_cross_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      temp_lo_d = temp_lo_q;
      dir_d     = dir_q;
      // Unsigned low-byte add; carry-out versus offset sign decides the fix-up
      sum       = {1'b0, pc_q[7:0]} + {1'b0, data_bus};

      unique case (state_q)
         S_IDLE: begin
            case (pc_op)
               OP_INC:      pc_d = pc_q + PC_W'(1);
               OP_LATCH_LO: temp_lo_d = data_bus;
               OP_JUMP:     pc_d = {data_bus, temp_lo_q};
               OP_BRANCH: begin
                  pc_d[7:0] = sum[7:0];
                  if (!data_bus[7] && sum[8]) begin
                     state_d = S_FIXUP;
                     dir_d   = 1'b0;
                  end else if (data_bus[7] && !sum[8]) begin
                     state_d = S_FIXUP;
                     dir_d   = 1'b1;
                  end
               end
               OP_SET_LO:   pc_d[7:0]  = data_bus;
               OP_SET_HI:   pc_d[15:8] = data_bus;
               default:     pc_d = pc_q;   // HOLD and reserved op 7
            endcase
         end
         S_FIXUP: begin
            pc_d[15:8] = dir_q ? (pc_q[15:8] - BYTE_W'(1)) : (pc_q[15:8] + BYTE_W'(1));
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d       = (state_d == S_FIXUP);
      page_cross_d = (state_d == S_FIXUP);
   end

   assign pc_out     = pc_q;
   assign busy       = busy_q;
   assign page_cross = page_cross_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver pushes the expected post-edge
// state for every applied cycle; the monitor pops and compares after each edge.
module tb_pc_unit;

   logic        clk_1;
   logic        rst;
   logic [2:0]  pc_op;
   logic [7:0]  data_bus;
   logic [15:0] pc_out;
   logic        busy;
   logic        page_cross;

   typedef struct packed {
      logic [15:0] pc;
      logic        busy;
      logic        pcx;
   } exp_t;

   exp_t  sb_q[$];
   string name_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   pc_unit #(.RESET_PC(16'hFFFC)) dut (
      .clk_1      (clk_1),
      .rst        (rst),
      .pc_op      (pc_op),
      .data_bus   (data_bus),
      .pc_out     (pc_out),
      .busy       (busy),
      .page_cross (page_cross)
   );

   initial clk_1 = 1'b0;
   always #5 clk_1 = ~clk_1;

   task automatic chk(input string nm, input exp_t e);
      n_vec++;
      if (pc_out !== e.pc || busy !== e.busy || page_cross !== e.pcx) begin
         n_err++;
         $display("FAIL %s: got pc=%h busy=%b pcx=%b, want pc=%h busy=%b pcx=%b",
                  nm, pc_out, busy, page_cross, e.pc, e.busy, e.pcx);
      end
   endtask

   // Apply one op at the falling edge and queue the state expected after the next rise
   task automatic step(input string nm, input logic [2:0] op, input logic [7:0] d,
                       input logic [15:0] epc, input logic eb, input logic ep);
      exp_t e;
      @(negedge clk_1);
      pc_op    = op;
      data_bus = d;
      e.pc   = epc;
      e.busy = eb;
      e.pcx  = ep;
      sb_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: compare one queued expectation per clock edge
   always @(posedge clk_1) begin
      #1;
      if (sb_q.size() != 0) begin
         exp_t  e;
         string nm;
         e  = sb_q.pop_front();
         nm = name_q.pop_front();
         chk(nm, e);
      end
   end

   initial begin
      exp_t r;
      int   guard;
      r.pc = 16'hFFFC; r.busy = 1'b0; r.pcx = 1'b0;
      rst = 1'b1; pc_op = 3'd0; data_bus = 8'h00;
      #7;
      chk("reset_state", r);
      @(negedge clk_1);
      rst = 1'b0;

      step("inc_after_reset", 3'd1, 8'h00, 16'hFFFD, 1'b0, 1'b0);
      @(posedge clk_1);
      #3 rst = 1'b1;
      #1 chk("async_reset", r);
      @(negedge clk_1);
      rst = 1'b0; pc_op = 3'd0;

      step("inc1", 3'd1, 8'h00, 16'hFFFD, 1'b0, 1'b0);
      step("inc2", 3'd1, 8'h00, 16'hFFFE, 1'b0, 1'b0);
      step("inc3", 3'd1, 8'h00, 16'hFFFF, 1'b0, 1'b0);
      step("inc_wrap", 3'd1, 8'h00, 16'h0000, 1'b0, 1'b0);

      step("latch_lo", 3'd2, 8'h34, 16'h0000, 1'b0, 1'b0);
      step("jump", 3'd3, 8'h12, 16'h1234, 1'b0, 1'b0);
      step("jump_keep_lo", 3'd3, 8'h56, 16'h5634, 1'b0, 1'b0);

      step("set_f0", 3'd2, 8'hF0, 16'h5634, 1'b0, 1'b0);
      step("jmp_12f0", 3'd3, 8'h12, 16'h12F0, 1'b0, 1'b0);
      step("fwd_br_e1", 3'd4, 8'h20, 16'h1210, 1'b1, 1'b1);
      step("fwd_br_e2_inc_ignored", 3'd1, 8'h00, 16'h1310, 1'b0, 1'b0);
      step("fwd_br_hold", 3'd0, 8'h00, 16'h1310, 1'b0, 1'b0);

      step("set_05", 3'd2, 8'h05, 16'h1310, 1'b0, 1'b0);
      step("jmp_1205", 3'd3, 8'h12, 16'h1205, 1'b0, 1'b0);
      step("bwd_br_e1", 3'd4, 8'hF0, 16'h12F5, 1'b1, 1'b1);
      step("bwd_br_e2", 3'd0, 8'h00, 16'h11F5, 1'b0, 1'b0);

      step("set_20", 3'd2, 8'h20, 16'h11F5, 1'b0, 1'b0);
      step("jmp_1220", 3'd3, 8'h12, 16'h1220, 1'b0, 1'b0);
      step("bwd_same_page", 3'd4, 8'hF0, 16'h1210, 1'b0, 1'b0);
      step("bwd_same_hold", 3'd0, 8'h00, 16'h1210, 1'b0, 1'b0);

      step("set_05b", 3'd2, 8'h05, 16'h1210, 1'b0, 1'b0);
      step("jmp_0005", 3'd3, 8'h00, 16'h0005, 1'b0, 1'b0);
      step("bwd_wrap_e1", 3'd4, 8'h80, 16'h0085, 1'b1, 1'b1);
      step("bwd_wrap_e2", 3'd0, 8'h00, 16'hFF85, 1'b0, 1'b0);

      step("set_f0b", 3'd2, 8'hF0, 16'hFF85, 1'b0, 1'b0);
      step("jmp_fff0", 3'd3, 8'hFF, 16'hFFF0, 1'b0, 1'b0);
      step("fwd_wrap_e1", 3'd4, 8'h20, 16'hFF10, 1'b1, 1'b1);
      step("fwd_wrap_e2", 3'd0, 8'h00, 16'h0010, 1'b0, 1'b0);

      step("set_cd", 3'd2, 8'hCD, 16'h0010, 1'b0, 1'b0);
      step("jmp_abcd", 3'd3, 8'hAB, 16'hABCD, 1'b0, 1'b0);
      step("set_lo", 3'd5, 8'h11, 16'hAB11, 1'b0, 1'b0);
      step("set_hi", 3'd6, 8'h22, 16'h2211, 1'b0, 1'b0);
      step("op7_hold", 3'd7, 8'h99, 16'h2211, 1'b0, 1'b0);

      step("set_f0c", 3'd2, 8'hF0, 16'h2211, 1'b0, 1'b0);
      step("jmp_12f0b", 3'd3, 8'h12, 16'h12F0, 1'b0, 1'b0);
      step("br_before_rst", 3'd4, 8'h20, 16'h1210, 1'b1, 1'b1);
      @(posedge clk_1);
      #2 pc_op = 3'd0;
      #1 rst = 1'b1;
      #1 chk("rst_in_fixup", r);
      @(negedge clk_1);
      rst = 1'b0;
      step("br_after_rst", 3'd4, 8'h02, 16'hFFFE, 1'b0, 1'b0);
      step("br_after_rst_x_e1", 3'd4, 8'h10, 16'hFF0E, 1'b1, 1'b1);
      step("br_after_rst_x_e2", 3'd0, 8'h00, 16'h000E, 1'b0, 1'b0);

      guard = 0;
      while (sb_q.size() != 0 && guard < 20) begin
         @(negedge clk_1);
         guard++;
      end
      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program counter for the 6502-compatible core.
- Sits directly upstream of the address buffer and drives that block's pc_in.
- Supports increment, two-byte absolute jump, 8-bit-half loads for RTS/RTI stack pulls, and signed relative branches.
- A branch that crosses a page costs an extra high-byte fix-up cycle.

Parameters:
- RESET_PC, 16'hFFFC, value loaded into the PC on reset (reset vector fetch address).

Ports:
- clk_1  input  1  single system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- pc_op  input  3  operation select, sampled each posedge while not busy.
- data_bus  input  8  data byte: jump low/high byte, stack byte, or branch offset.
- pc_out  output  16  current program counter, registered; feeds the address buffer.
- busy  output  1  high during the branch fix-up cycle; pc_op is ignored while high.
- page_cross  output  1  high for exactly the fix-up cycle of a page-crossing branch.

Behaviour:
- Reset (async, rst=1):
  - pc_out=RESET_PC; internal temp_lo=8'h00.
  - State=IDLE; busy=0; page_cross=0.
  - Holds while rst is high; deasserting rst mid-fix-up still leaves IDLE at RESET_PC.
- pc_op encoding, all taking effect at the next posedge in IDLE:
  - 0 HOLD: no change.
  - 1 INC: pc <= pc+1, 16-bit modulo; 16'hFFFF -> 16'h0000.
  - 2 LATCH_LO: temp_lo <= data_bus; pc unchanged.
  - 3 JUMP: pc <= {data_bus, temp_lo}; temp_lo retained.
  - 4 BRANCH: signed 8-bit relative add of data_bus; see below.
  - 5 SET_LO: pc[7:0] <= data_bus; pc[15:8] unchanged.
  - 6 SET_HI: pc[15:8] <= data_bus; pc[7:0] unchanged.
  - 7: reserved, treated as HOLD.
- Branch, first cycle (IDLE):
  - sum = {1'b0, pc[7:0]} + {1'b0, data_bus}.
  - pc[7:0] <= sum[7:0].
  - Fix-up needed if (data_bus[7]==0 and sum[8]==1): high byte +1.
  - Fix-up needed if (data_bus[7]==1 and sum[8]==0): high byte -1.
  - Otherwise done in one cycle; state stays IDLE.
  - If fix-up needed: store direction, go to FIXUP, busy=1 and page_cross=1 (registered, visible the cycle after the branch edge).
- FIXUP state, one cycle:
  - pc[15:8] <= pc[15:8] ±1, modulo 256; 8'hFF+1 -> 8'h00, 8'h00-1 -> 8'hFF.
  - Return to IDLE; busy and page_cross drop to 0.
  - pc_op and data_bus are ignored during FIXUP; the controller must re-present any op after busy falls.
- Intermediate value: pc_out shows the partially updated value (new low byte, old high byte) during FIXUP, matching 6502 dummy-read behaviour.
- Latency:
  - All ops: 1 cycle.
  - Page-crossing branch: 2 cycles.
- Outputs are registered; there is no combinational path from pc_op or data_bus to pc_out.

Test Plan:
- Reset and increment:
  - Assert rst asynchronously mid-cycle -> pc_out=16'hFFFC immediately, busy=0.
  - Release rst, INC x4 -> 16'h0000 after the 4th edge (wrap from FFFF).
- Jump:
  - LATCH_LO with data_bus=8'h34, then JUMP with data_bus=8'h12 -> pc_out=16'h1234.
  - temp_lo is still 8'h34 (a second JUMP with 8'h56 -> 16'h5634).
- Forward page-crossing branch:
  - pc=16'h12F0, BRANCH data_bus=8'h20 -> edge 1: pc=16'h1210, busy=1, page_cross=1.
  - Edge 2: pc=16'h1310, busy=0.
  - INC presented during FIXUP is ignored.
- Backward branches:
  - pc=16'h1205, BRANCH 8'hF0 -> 16'h12F5 (busy=1), then 16'h11F5.
  - pc=16'h1220, BRANCH 8'hF0 -> 16'h1210 in one cycle, busy stays 0.
  - pc=16'h0005, BRANCH 8'h80 -> 16'h0085, then 16'hFF85 (high-byte wrap).
- Stack loads:
  - pc=16'hABCD, SET_LO 8'h11 -> 16'hAB11.
  - SET_HI 8'h22 -> 16'h2211.
  - op 7 -> unchanged.
- Reset mid-fix-up:
  - Assert rst during the FIXUP cycle -> pc_out=16'hFFFC, busy=0, page_cross=0.
  - The next BRANCH behaves normally.
